// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl_pkg
//  Description : Shared definitions for the P5 fetch stage: default reset PC,
//                instruction-memory depth, NOP encoding, AdEL exception code,
//                FSM state encoding and the F/D pipeline register payload.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_ctrl_pkg;

    localparam logic [31:0] PC_RESET_DEF  = 32'h0000_3000;
    localparam int          IM_DEPTH_DEF  = 4096;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [4:0]  EXC_ADEL      = 5'd4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        adel;
        logic [4:0]  excode;
    } fd_t;

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl_fd_reg.sv
`default_nettype none
// ============================================================================
//  Module      : fd_reg
//  Description : F/D pipeline register. Loads the next payload when en is
//                high, holds otherwise. Synchronous active-high reset puts a
//                NOP tagged with the reset PC into the register, marked invalid.
//  Ports       : clk, reset, en (load enable), d (next payload), q (payload)
//  Revision    : 1.0  initial release
// ============================================================================
module fd_reg
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = PC_RESET_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  fd_t  d,
    output fd_t  q
);

    fd_t r_fd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fd.instr  <= NOP_INSTR;
            r_fd.pc     <= PC_RESET;
            r_fd.valid  <= 1'b0;
            r_fd.adel   <= 1'b0;
            r_fd.excode <= 5'd0;
        end else if (en) begin
            r_fd <= d;
        end
    end

    assign q = r_fd;

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : F stage sequencer for the P5 pipeline. Owns the PC, drives
//                the combinational IM word address, and loads the F/D
//                register with delay-slot redirect semantics. An out-of-range
//                or misaligned PC halts fetch until reset, or, when the
//                FETCH_ADEL_EN macro is defined, is passed down as an AdEL
//                tagged NOP while fetching continues.
//  Ports       : clk, reset            clock / sync active-high reset
//                stall                 hold PC and F/D
//                redirect, redirect_pc next PC override from D stage
//                im_addr, im_instr     IM word index / same-cycle read data
//                f_pc                  current fetch PC
//                d_instr, d_pc, d_valid, d_adel, d_excode   F/D register
//                halted                fetch stopped (HALT state)
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = PC_RESET_DEF,
    parameter int          IM_DEPTH  = IM_DEPTH_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter int          IM_AW     = $clog2(IM_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic [IM_AW-1:0] im_addr,
    input  logic [31:0]      im_instr,
    output logic [31:0]      f_pc,
    output logic [31:0]      d_instr,
    output logic [31:0]      d_pc,
    output logic             d_valid,
    output logic             halted,
    output logic             d_adel,
    output logic [4:0]       d_excode
);

    // One past the last valid byte address; 33 bits so the window end never wraps.
    localparam logic [32:0] c_pc_end = {1'b0, PC_RESET} + 33'(4 * IM_DEPTH);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_pc_seq;
    logic        w_pc_ok;
    logic        w_fd_en;
    fd_t         w_fd_d;
    fd_t         w_fd_q;

    assign w_pc_ok = (r_pc >= PC_RESET) && ({1'b0, r_pc} < c_pc_end) && (r_pc[1:0] == 2'b00);
    assign w_pc_seq = redirect ? redirect_pc : (r_pc + 32'd4);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_BOOT;
            r_pc    <= PC_RESET;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_fd_en     = 1'b0;
        w_fd_d      = w_fd_q;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!stall) begin
                    w_fd_en = 1'b1;
                    if (w_pc_ok) begin
                        w_fd_d   = '{instr: im_instr, pc: r_pc, valid: 1'b1,
                                     adel: 1'b0, excode: 5'd0};
                        w_pc_nxt = w_pc_seq;
                    end else begin
`ifdef FETCH_ADEL_EN
                        // Faulting fetch travels down the pipe as a valid NOP
                        // carrying the bad PC; the exception unit handles it.
                        w_fd_d   = '{instr: NOP_INSTR, pc: r_pc, valid: 1'b1,
                                     adel: 1'b1, excode: EXC_ADEL};
                        w_pc_nxt = w_pc_seq;
`else
                        // d_pc keeps the last good fetch address.
                        w_fd_d      = '{instr: NOP_INSTR, pc: w_fd_q.pc, valid: 1'b0,
                                        adel: 1'b0, excode: 5'd0};
                        w_state_nxt = ST_HALT;
`endif
                    end
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_HALT;
            end
        endcase
    end

    fd_reg #(
        .PC_RESET  (PC_RESET),
        .NOP_INSTR (NOP_INSTR)
    ) u_fd_reg (
        .clk   (clk),
        .reset (reset),
        .en    (w_fd_en),
        .d     (w_fd_d),
        .q     (w_fd_q)
    );

    // Offset truncated to the word index; meaningless when the PC is out of range.
    assign im_addr  = IM_AW'((r_pc - PC_RESET) >> 2);
    assign f_pc     = r_pc;
    assign d_instr  = w_fd_q.instr;
    assign d_pc     = w_fd_q.pc;
    assign d_valid  = w_fd_q.valid;
    assign d_adel   = w_fd_q.adel;
    assign d_excode = w_fd_q.excode;
    assign halted   = (r_state == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_ctrl
//  Description : Self-checking bench for fetch_ctrl: directed scenarios then
//                random stall/redirect/reset traffic against a cycle model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam logic [31:0] c_base  = 32'h0000_3000;
    localparam longint      c_depth = 4096;

    logic        clk = 1'b0;
    logic        reset, stall, redirect;
    logic [31:0] redirect_pc;
    logic [11:0] im_addr;
    logic [31:0] im_instr;
    logic [31:0] f_pc, d_instr, d_pc;
    logic        d_valid, halted, d_adel;
    logic [4:0]  d_excode;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] m_pc, m_instr, m_dpc;
    logic        m_valid, m_adel, m_halt, m_boot;
    logic [4:0]  m_exc;
    int          halt_cnt;

    fetch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .im_addr     (im_addr),
        .im_instr    (im_instr),
        .f_pc        (f_pc),
        .d_instr     (d_instr),
        .d_pc        (d_pc),
        .d_valid     (d_valid),
        .halted      (halted),
        .d_adel      (d_adel),
        .d_excode    (d_excode)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] idx);
        return 32'hA500_0000 ^ (idx * 32'h9E37_79B1);
    endfunction

    // instruction memory contents
    always_comb im_instr = mem_word({20'd0, im_addr});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_window(input logic [31:0] pc);
        longint p;
        p = longint'(pc);
        return (p >= longint'(c_base)) && (p < longint'(c_base) + 4 * c_depth) && (pc % 4 == 0);
    endfunction

    task automatic check_all();
        chk("f_pc",     f_pc,            m_pc);
        chk("d_instr",  d_instr,         m_instr);
        chk("d_pc",     d_pc,            m_dpc);
        chk("d_valid",  {31'd0, d_valid}, {31'd0, m_valid});
        chk("halted",   {31'd0, halted},  {31'd0, m_halt});
        chk("d_adel",   {31'd0, d_adel},  {31'd0, m_adel});
        chk("d_excode", {27'd0, d_excode}, {27'd0, m_exc});
    endtask

    // One clock: apply inputs, advance the model, check after the edge.
    task automatic cycle(input logic rst, input logic st, input logic rd, input logic [31:0] rpc);
        logic [31:0] nxt;
        reset = rst; stall = st; redirect = rd; redirect_pc = rpc;
        #1;
        if (!rst && in_window(m_pc))
            chk("im_addr", {20'd0, im_addr}, (m_pc - c_base) / 4);
        nxt = rd ? rpc : m_pc + 32'd4;
        if (rst) begin
            m_pc = c_base; m_instr = 32'd0; m_dpc = c_base; m_valid = 1'b0;
            m_adel = 1'b0; m_exc = 5'd0; m_halt = 1'b0; m_boot = 1'b1;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (!m_halt && !st) begin
            if (in_window(m_pc)) begin
                m_instr = mem_word((m_pc - c_base) / 4);
                m_dpc = m_pc; m_valid = 1'b1; m_adel = 1'b0; m_exc = 5'd0;
                m_pc = nxt;
            end else begin
`ifdef FETCH_ADEL_EN
                m_instr = 32'd0; m_dpc = m_pc; m_valid = 1'b1;
                m_adel = 1'b1; m_exc = 5'd4; m_pc = nxt;
`else
                m_instr = 32'd0; m_valid = 1'b0; m_halt = 1'b1;
`endif
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] hold_pc, hold_instr, hold_dpc, rpc;
        int r;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        m_pc = c_base; m_instr = 32'd0; m_dpc = c_base; m_valid = 1'b0;
        m_adel = 1'b0; m_exc = 5'd0; m_halt = 1'b0; m_boot = 1'b1;
        halt_cnt = 0;
        @(negedge clk);

        // 1: reset, BOOT bubble, first two fetches
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("rst_dvalid", {31'd0, d_valid}, 32'd0);
        chk("rst_fpc", f_pc, 32'h3000);
        cycle(0, 1, 0, 0);                      // BOOT ignores stall
        chk("boot_dvalid", {31'd0, d_valid}, 32'd0);
        chk("boot_fpc", f_pc, 32'h3000);
        cycle(0, 0, 0, 0);
        chk("i0_pc", d_pc, 32'h3000);
        chk("i0_instr", d_instr, mem_word(0));
        cycle(0, 0, 0, 0);
        chk("i1_pc", d_pc, 32'h3004);

        // 2: stall holds everything
        hold_pc = f_pc; hold_instr = d_instr; hold_dpc = d_pc;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 0);
            chk("stall_fpc", f_pc, hold_pc);
            chk("stall_instr", d_instr, hold_instr);
            chk("stall_dpc", d_pc, hold_dpc);
        end
        cycle(0, 0, 0, 0);
        chk("unstall_dpc", d_pc, 32'h3008);

        // 3: redirect with delay slot
        cycle(0, 0, 1, 32'h3100);
        chk("dslot_pc", d_pc, 32'h300C);
        chk("dslot_valid", {31'd0, d_valid}, 32'd1);
        cycle(0, 0, 0, 0);
        chk("target_pc", d_pc, 32'h3100);

        // 4: redirect under stall is dropped
        hold_pc = f_pc;
        cycle(0, 1, 1, 32'h3200);
        chk("stall_redir_fpc", f_pc, hold_pc);
        cycle(0, 0, 1, 32'h3200);
        chk("redir_fpc", f_pc, 32'h3200);
        cycle(0, 0, 0, 0);
        chk("redir_dpc", d_pc, 32'h3200);

`ifndef FETCH_ADEL_EN
        // 5: out-of-range target halts fetch until reset
        cycle(0, 0, 1, 32'h7000);
        cycle(0, 0, 0, 0);
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_dvalid", {31'd0, d_valid}, 32'd0);
        chk("halt_instr", d_instr, 32'd0);
        for (int i = 0; i < 10; i++) cycle(0, $urandom_range(0, 1), 1, 32'h3000);
        chk("halt_hold_fpc", f_pc, 32'h7000);
        cycle(1, 0, 0, 0);
        chk("halt_rst_fpc", f_pc, 32'h3000);
        chk("halt_rst_halted", {31'd0, halted}, 32'd0);
`else
        // 6: misaligned target raises AdEL, fetch continues
        cycle(0, 0, 1, 32'h3002);
        cycle(0, 0, 1, 32'h4180);
        chk("adel_flag", {31'd0, d_adel}, 32'd1);
        chk("adel_exc", {27'd0, d_excode}, 32'd4);
        chk("adel_instr", d_instr, 32'd0);
        chk("adel_pc", d_pc, 32'h3002);
        cycle(0, 0, 0, 0);
        chk("adel_clr", {31'd0, d_adel}, 32'd0);
        chk("adel_next_pc", d_pc, 32'h4180);
        cycle(1, 0, 0, 0);
`endif

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 19);
            case (r)
                0:       rpc = 32'h8000 + 4 * $urandom_range(0, 255);
                1:       rpc = c_base + 4 * $urandom_range(0, 4095) + $urandom_range(1, 3);
                2:       rpc = 32'h6FFC;
                3:       rpc = 32'h2FFC;
                default: rpc = c_base + 4 * $urandom_range(0, 4095);
            endcase
            halt_cnt = m_halt ? halt_cnt + 1 : 0;
            cycle(($urandom_range(0, 99) == 0) || (halt_cnt > 5),
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0,
                  rpc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
